// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and burst helpers for the multi-layer switch slave port.
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic HRESP_OKAY = 1'b0;

  // Beats remaining after the NONSEQ beat; undefined-length bursts report 0.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_SINGLE, HBURST_INCR:   return 4'd0;
      HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
      HBURST_WRAP16, HBURST_INCR16: return 4'd15;
      default:                      return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb3lite_interconnect_wrr_pick.sv
// Combinational picker: highest requesting priority level, then round-robin
// starting just after that level's pointer.
module ahb3lite_interconnect_wrr_pick #(
  parameter int MASTERS     = 4,
  parameter int MASTER_BITS = 2
) (
  input  logic [MASTERS-1:0]                        hsel,
  input  logic [MASTERS*MASTER_BITS-1:0]            priorities,
  input  logic [(2**MASTER_BITS)*MASTER_BITS-1:0]   rr_ptr,
  output logic [MASTER_BITS-1:0]                    level,
  output logic [MASTER_BITS-1:0]                    pick,
  output logic                                      valid
);

  localparam int LEVELS = 2 ** MASTER_BITS;

  logic [MASTER_BITS-1:0] prio_a [MASTERS];
  logic [MASTER_BITS-1:0] ptr_a  [LEVELS];
  logic [MASTER_BITS-1:0] ptr;
  logic [MASTERS-1:0]     cand;
  logic                   found;

  always_comb begin
    level = '0;
    valid = 1'b0;
    for (int m = 0; m < MASTERS; m++) begin
      prio_a[m] = priorities[m*MASTER_BITS +: MASTER_BITS];
      if (hsel[m] && (!valid || prio_a[m] > level)) begin
        level = prio_a[m];
        valid = 1'b1;
      end
    end
    for (int l = 0; l < LEVELS; l++) begin
      ptr_a[l] = rr_ptr[l*MASTER_BITS +: MASTER_BITS];
    end
    ptr = ptr_a[level];
    for (int m = 0; m < MASTERS; m++) begin
      cand[m] = hsel[m] && (prio_a[m] == level);
    end
    // First pass scans above the pointer, second pass wraps to the bottom.
    pick  = '0;
    found = 1'b0;
    for (int m = 0; m < MASTERS; m++) begin
      if (!found && cand[m] && (m > int'(ptr))) begin
        pick  = MASTER_BITS'(m);
        found = 1'b1;
      end
    end
    for (int m = 0; m < MASTERS; m++) begin
      if (!found && cand[m]) begin
        pick  = MASTER_BITS'(m);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb3lite_interconnect_slave_port_wrr.sv
// Slave-port arbiter/mux: priority then weighted round-robin, switching only at
// burst boundaries, never under HMASTLOCK, with a per-tenure transfer quantum.
module ahb3lite_interconnect_slave_port_wrr
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MASTERS     = 4,
  parameter int WEIGHT_BITS = 4,
  localparam int MASTER_BITS = (MASTERS == 1) ? 1 : $clog2(MASTERS)
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [MASTERS*MASTER_BITS-1:0] mst_priority,
  input  logic [MASTERS*WEIGHT_BITS-1:0] mst_weight,
  input  logic [MASTERS-1:0]             mstHSEL,
  input  logic [MASTERS*HADDR_SIZE-1:0]  mstHADDR,
  input  logic [MASTERS*HDATA_SIZE-1:0]  mstHWDATA,
  input  logic [MASTERS-1:0]             mstHWRITE,
  input  logic [MASTERS*3-1:0]           mstHSIZE,
  input  logic [MASTERS*3-1:0]           mstHBURST,
  input  logic [MASTERS*4-1:0]           mstHPROT,
  input  logic [MASTERS*2-1:0]           mstHTRANS,
  input  logic [MASTERS-1:0]             mstHMASTLOCK,
  input  logic [MASTERS-1:0]             mstHREADY,
  output logic [HDATA_SIZE-1:0]          mstHRDATA,
  output logic [MASTERS-1:0]             mstHREADYOUT,
  output logic [MASTERS-1:0]             mstHRESP,
  output logic                           slv_HSEL,
  output logic [HADDR_SIZE-1:0]          slv_HADDR,
  output logic [HDATA_SIZE-1:0]          slv_HWDATA,
  output logic                           slv_HWRITE,
  output logic [2:0]                     slv_HSIZE,
  output logic [2:0]                     slv_HBURST,
  output logic [3:0]                     slv_HPROT,
  output logic [1:0]                     slv_HTRANS,
  output logic                           slv_HMASTLOCK,
  output logic                           slv_HREADYOUT,
  input  logic [HDATA_SIZE-1:0]          slv_HRDATA,
  input  logic                           slv_HREADY,
  input  logic                           slv_HRESP,
  output logic [MASTERS-1:0]             granted_master
);

  localparam int LEVELS = 2 ** MASTER_BITS;

  logic [HADDR_SIZE-1:0]  addr_a   [MASTERS];
  logic [HDATA_SIZE-1:0]  wdata_a  [MASTERS];
  logic [2:0]             size_a   [MASTERS];
  logic [2:0]             burst_a  [MASTERS];
  logic [3:0]             prot_a   [MASTERS];
  logic [1:0]             trans_a  [MASTERS];
  logic [WEIGHT_BITS-1:0] weight_a [MASTERS];

  for (genvar i = 0; i < MASTERS; i++) begin : g_unpack
    assign addr_a[i]   = mstHADDR[i*HADDR_SIZE +: HADDR_SIZE];
    assign wdata_a[i]  = mstHWDATA[i*HDATA_SIZE +: HDATA_SIZE];
    assign size_a[i]   = mstHSIZE[i*3 +: 3];
    assign burst_a[i]  = mstHBURST[i*3 +: 3];
    assign prot_a[i]   = mstHPROT[i*4 +: 4];
    assign trans_a[i]  = mstHTRANS[i*2 +: 2];
    assign weight_a[i] = mst_weight[i*WEIGHT_BITS +: WEIGHT_BITS];
  end

  logic [MASTER_BITS-1:0] g_q, g_d, d_q, d_d;
  logic [3:0]             burst_left_q, burst_left_d;
  logic [WEIGHT_BITS-1:0] q_cnt_q, q_cnt_d;
  logic                   first_beat_q, first_beat_d;
  logic [MASTER_BITS-1:0] rr_ptr_q [LEVELS];
  logic [MASTER_BITS-1:0] rr_ptr_d [LEVELS];
  logic [LEVELS*MASTER_BITS-1:0] rr_ptr_flat;

  logic [MASTER_BITS-1:0] pk_level, pk_pick;
  logic                   pk_valid;

  always_comb begin
    for (int l = 0; l < LEVELS; l++) begin
      rr_ptr_flat[l*MASTER_BITS +: MASTER_BITS] = rr_ptr_q[l];
    end
  end

  ahb3lite_interconnect_wrr_pick #(
    .MASTERS     (MASTERS),
    .MASTER_BITS (MASTER_BITS)
  ) u_pick (
    .hsel       (mstHSEL),
    .priorities (mst_priority),
    .rr_ptr     (rr_ptr_flat),
    .level      (pk_level),
    .pick       (pk_pick),
    .valid      (pk_valid)
  );

  logic                   sel_g, lock_g, accept, burst_end, quantum_done, switch_ok;
  logic [1:0]             trans_g, eff_trans;
  logic [2:0]             burst_g;
  logic [3:0]             beats;
  logic [WEIGHT_BITS-1:0] weight_eff;

  always_comb begin
    sel_g   = mstHSEL[g_q];
    lock_g  = mstHMASTLOCK[g_q];
    trans_g = trans_a[g_q];
    burst_g = burst_a[g_q];
    // A master granted mid-burst must not present SEQ to a slave it never addressed.
    eff_trans = (first_beat_q && trans_g == HTRANS_SEQ) ? HTRANS_NONSEQ : trans_g;
    accept    = slv_HREADY & sel_g & trans_g[1];
    beats     = burst_beats(burst_g);
    burst_end = accept & ((eff_trans == HTRANS_NONSEQ && beats == 4'd0) ||
                          (eff_trans == HTRANS_SEQ && burst_left_q == 4'd1) ||
                          (burst_g == HBURST_INCR));
    weight_eff   = (weight_a[g_q] == '0) ? WEIGHT_BITS'(1) : weight_a[g_q];
    quantum_done = ({1'b0, q_cnt_q} + (WEIGHT_BITS+1)'(1)) >= {1'b0, weight_eff};
    switch_ok    = slv_HREADY & (~sel_g | (trans_g == HTRANS_IDLE & ~lock_g) |
                                 (accept & ~lock_g & burst_end & quantum_done));

    g_d          = g_q;
    d_d          = slv_HREADY ? g_q : d_q;
    burst_left_d = burst_left_q;
    q_cnt_d      = q_cnt_q;
    first_beat_d = first_beat_q;
    rr_ptr_d     = rr_ptr_q;

    if (accept) begin
      if (eff_trans == HTRANS_NONSEQ) burst_left_d = beats;
      else if (burst_left_q != 4'd0)  burst_left_d = burst_left_q - 4'd1;
      if (q_cnt_q != '1) q_cnt_d = q_cnt_q + WEIGHT_BITS'(1);
      first_beat_d = 1'b0;
    end

    if (switch_ok) begin
      q_cnt_d = '0;
      if (pk_valid) begin
        g_d                = pk_pick;
        rr_ptr_d[pk_level] = pk_pick;
        if (pk_pick != g_q) first_beat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      g_q          <= '0;
      d_q          <= '0;
      burst_left_q <= '0;
      q_cnt_q      <= '0;
      first_beat_q <= 1'b0;
      for (int l = 0; l < LEVELS; l++) rr_ptr_q[l] <= '0;
    end else begin
      g_q          <= g_d;
      d_q          <= d_d;
      burst_left_q <= burst_left_d;
      q_cnt_q      <= q_cnt_d;
      first_beat_q <= first_beat_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // Slave-side HREADY input follows the granted master's bus HREADY.
  always_comb begin
    slv_HSEL      = sel_g;
    slv_HADDR     = addr_a[g_q];
    slv_HWDATA    = wdata_a[d_q];
    slv_HWRITE    = mstHWRITE[g_q];
    slv_HSIZE     = size_a[g_q];
    slv_HBURST    = burst_g;
    slv_HPROT     = prot_a[g_q];
    slv_HTRANS    = eff_trans;
    slv_HMASTLOCK = lock_g;
    slv_HREADYOUT = mstHREADY[g_q];
    mstHRDATA     = slv_HRDATA;
    for (int m = 0; m < MASTERS; m++) begin
      granted_master[m] = (g_q == MASTER_BITS'(m));
      if (d_q == MASTER_BITS'(m)) begin
        mstHREADYOUT[m] = slv_HREADY;
        mstHRESP[m]     = slv_HRESP;
      end else begin
        mstHREADYOUT[m] = !((g_q != MASTER_BITS'(m)) && mstHSEL[m] && trans_a[m][1]);
        mstHRESP[m]     = HRESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_port_wrr.sv
// Directed bench for the WRR slave-port arbiter: alternation, burst atomicity,
// weights, locked bursts, SEQ rewrite and mid-burst reset.
module tb_ahb3lite_interconnect_slave_port_wrr;

  localparam int M = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [7:0]    mst_priority;
  logic [15:0]   mst_weight;
  logic [3:0]    mstHSEL, mstHWRITE, mstHMASTLOCK, mstHREADY;
  logic [127:0]  mstHADDR, mstHWDATA;
  logic [11:0]   mstHSIZE, mstHBURST;
  logic [15:0]   mstHPROT;
  logic [7:0]    mstHTRANS;
  logic [31:0]   mstHRDATA;
  logic [3:0]    mstHREADYOUT, mstHRESP;
  logic          slv_HSEL, slv_HWRITE, slv_HMASTLOCK, slv_HREADYOUT;
  logic [31:0]   slv_HADDR, slv_HWDATA;
  logic [2:0]    slv_HSIZE, slv_HBURST;
  logic [3:0]    slv_HPROT;
  logic [1:0]    slv_HTRANS;
  logic [31:0]   slv_HRDATA;
  logic          slv_HREADY, slv_HRESP;
  logic [3:0]    granted_master;

  int n_checks = 0;
  int n_errs   = 0;
  logic [3:0] exp_q[$];

  ahb3lite_interconnect_slave_port_wrr #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(M), .WEIGHT_BITS(4)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .mst_priority(mst_priority), .mst_weight(mst_weight),
    .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA),
    .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST),
    .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS), .mstHMASTLOCK(mstHMASTLOCK),
    .mstHREADY(mstHREADY), .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT),
    .mstHRESP(mstHRESP), .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR),
    .slv_HWDATA(slv_HWDATA), .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE),
    .slv_HBURST(slv_HBURST), .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS),
    .slv_HMASTLOCK(slv_HMASTLOCK), .slv_HREADYOUT(slv_HREADYOUT),
    .slv_HRDATA(slv_HRDATA), .slv_HREADY(slv_HREADY), .slv_HRESP(slv_HRESP),
    .granted_master(granted_master)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic sample();
    @(negedge HCLK);
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
  endtask

  task automatic clear_all();
    mst_priority = '0; mst_weight = '0;
    mstHSEL = '0; mstHWRITE = '0; mstHMASTLOCK = '0; mstHREADY = '1;
    mstHADDR = '0; mstHWDATA = '0; mstHSIZE = '0; mstHBURST = '0;
    mstHPROT = '0; mstHTRANS = '0;
    slv_HRDATA = 32'hC0DE_0001; slv_HREADY = 1'b1; slv_HRESP = 1'b0;
  endtask

  task automatic drive(input int m, input logic sel, input logic [1:0] trans,
                       input logic [2:0] burst, input logic lock);
    mstHSEL[m]          = sel;
    mstHTRANS[m*2 +: 2] = trans;
    mstHBURST[m*3 +: 3] = burst;
    mstHMASTLOCK[m]     = lock;
  endtask

  task automatic set_addr(input int m, input logic [31:0] a, input logic [31:0] w);
    mstHADDR[m*32 +: 32]  = a;
    mstHWDATA[m*32 +: 32] = w;
  endtask

  initial begin
    clear_all();
    HRESET = 1'b1;
    tick();
    do_reset();

    // Reset state
    sample();
    chk("rst_grant", 32'(granted_master), 32'h1);
    chk("rst_hreadyout", 32'(mstHREADYOUT), 32'hF);
    chk("rst_hresp", 32'(mstHRESP), 32'h0);
    chk("rst_hrdata", mstHRDATA, 32'hC0DE_0001);

    // 1: equal priority SINGLEs alternate; m0 weight 0 acts as 1
    clear_all();
    mst_weight = 16'h0010;
    set_addr(0, 32'h100, 32'hA0);
    set_addr(1, 32'h200, 32'hB1);
    drive(0, 1'b1, 2'b10, 3'd0, 1'b0);
    drive(1, 1'b1, 2'b10, 3'd0, 1'b0);
    do_reset();
    sample();
    chk("t1_grant_a", 32'(granted_master), 32'h1);
    chk("t1_haddr_a", slv_HADDR, 32'h100);
    chk("t1_hreadyout_a", 32'(mstHREADYOUT), 32'hD);
    tick();
    sample();
    chk("t1_grant_b", 32'(granted_master), 32'h2);
    chk("t1_haddr_b", slv_HADDR, 32'h200);
    chk("t1_hwdata_b", slv_HWDATA, 32'hA0);
    chk("t1_hreadyout_b", 32'(mstHREADYOUT), 32'hF);
    tick();
    slv_HRESP = 1'b1;
    sample();
    chk("t1_grant_c", 32'(granted_master), 32'h1);
    chk("t1_hwdata_c", slv_HWDATA, 32'hB1);
    chk("t1_hresp_c", 32'(mstHRESP), 32'h2);
    tick();
    slv_HRESP = 1'b0;
    sample();
    chk("t1_grant_d", 32'(granted_master), 32'h2);

    // 2: m0 INCR4 is not interleaved; m1 joins at beat 2
    clear_all();
    mst_weight = 16'h0011;
    set_addr(1, 32'h222, 32'h0);
    drive(0, 1'b1, 2'b10, 3'd3, 1'b0);
    do_reset();
    sample();
    chk("t2_grant_b1", 32'(granted_master), 32'h1);
    tick();
    drive(0, 1'b1, 2'b11, 3'd3, 1'b0);
    drive(1, 1'b1, 2'b10, 3'd0, 1'b0);
    for (int b = 2; b <= 4; b++) begin
      sample();
      chk($sformatf("t2_grant_b%0d", b), 32'(granted_master), 32'h1);
      chk($sformatf("t2_htrans_b%0d", b), 32'(slv_HTRANS), 32'h3);
      chk($sformatf("t2_m1_wait_b%0d", b), 32'(mstHREADYOUT[1]), 32'h0);
      tick();
    end
    drive(0, 1'b0, 2'b00, 3'd0, 1'b0);
    sample();
    chk("t2_grant_m1", 32'(granted_master), 32'h2);
    chk("t2_htrans_m1", 32'(slv_HTRANS), 32'h2);
    chk("t2_haddr_m1", slv_HADDR, 32'h222);

    // 3: weights 3:1 over INCR single beats
    clear_all();
    mst_weight = 16'h0013;
    drive(0, 1'b1, 2'b10, 3'd1, 1'b0);
    drive(1, 1'b1, 2'b10, 3'd1, 1'b0);
    exp_q = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h1, 4'h1, 4'h1, 4'h2};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      sample();
      chk($sformatf("t3_grant_%0d", c), 32'(granted_master), 32'(exp_q.pop_front()));
      tick();
    end

    // 4: locked pair of INCR8 bursts holds off a higher-priority m2
    clear_all();
    mst_priority = 8'b00_11_00_00;
    mst_weight   = 16'h0111;
    drive(0, 1'b1, 2'b10, 3'd5, 1'b1);
    drive(2, 1'b1, 2'b10, 3'd0, 1'b0);
    do_reset();
    sample();
    chk("t4_lock_out", 32'(slv_HMASTLOCK), 32'h1);
    for (int c = 0; c < 17; c++) begin
      if (c == 8)       drive(0, 1'b1, 2'b10, 3'd5, 1'b1);
      else if (c == 16) drive(0, 1'b1, 2'b00, 3'd5, 1'b0);
      else if (c != 0)  drive(0, 1'b1, 2'b11, 3'd5, 1'b1);
      sample();
      chk($sformatf("t4_grant_%0d", c), 32'(granted_master), 32'h1);
      chk($sformatf("t4_m2_wait_%0d", c), 32'(mstHREADYOUT[2]), 32'h0);
      tick();
    end
    sample();
    chk("t4_grant_m2", 32'(granted_master), 32'h4);
    chk("t4_lock_m2", 32'(slv_HMASTLOCK), 32'h0);

    // 5: first granted SEQ is presented as NONSEQ
    clear_all();
    mst_weight = 16'h0040;
    drive(1, 1'b1, 2'b11, 3'd1, 1'b0);
    do_reset();
    sample();
    chk("t5_htrans_idle", 32'(slv_HTRANS), 32'h0);
    tick();
    sample();
    chk("t5_grant", 32'(granted_master), 32'h2);
    chk("t5_htrans_first", 32'(slv_HTRANS), 32'h2);
    tick();
    sample();
    chk("t5_htrans_next", 32'(slv_HTRANS), 32'h3);

    // 6: reset in the middle of an INCR16 with the slave stalling
    clear_all();
    mst_weight = 16'h0010;
    set_addr(0, 32'h0ABC, 32'h0);
    set_addr(1, 32'h1DEF, 32'h0);
    drive(1, 1'b1, 2'b10, 3'd7, 1'b0);
    do_reset();
    tick();
    sample();
    chk("t6_grant_m1", 32'(granted_master), 32'h2);
    tick();
    drive(1, 1'b1, 2'b11, 3'd7, 1'b0);
    tick();
    tick();
    slv_HREADY = 1'b0;
    HRESET     = 1'b1;
    sample();
    chk("t6_burst_left_mid", 32'(dut.burst_left_q), 32'd13);
    tick();
    HRESET     = 1'b0;
    slv_HREADY = 1'b1;
    sample();
    chk("t6_grant_rst", 32'(granted_master), 32'h1);
    chk("t6_qcnt_rst", 32'(dut.q_cnt_q), 32'h0);
    chk("t6_burst_left_rst", 32'(dut.burst_left_q), 32'h0);
    chk("t6_haddr_rst", slv_HADDR, 32'h0ABC);
    chk("t6_hsel_rst", 32'(slv_HSEL), 32'h0);
    chk("t6_hreadyout_rst", 32'(mstHREADYOUT), 32'hD);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
